// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus of the round-robin memory arbiter.
// slave is the arbiter's view; master is the requester/memory environment's view.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [DATA_W-1:0]              resp_rdata;
  logic                           mem_req_valid;
  logic                           mem_we;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic                           mem_req_ready;
  logic                           mem_resp_valid;
  logic [DATA_W-1:0]              mem_rdata;
  logic                           busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters,
// one transaction in flight: grant, issue, wait for response, return to owner.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ptr, sel, win, cand;
  logic               found;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;

  // Search starts just after the last grant, so that requester ranks lowest.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found)              state_nx = ISSUE;
      ISSUE:   if (bus.mem_req_ready)  state_nx = WAIT;
      WAIT:    if (bus.mem_resp_valid) state_nx = RESPOND;
      RESPOND:                         state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= PTR_RST;
      sel     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (found) begin
          sel     <= win;
          we_q    <= bus.req_we[win];
          addr_q  <= bus.req_addr[win];
          wdata_q <= bus.req_wdata[win];
        end
        WAIT:    if (bus.mem_resp_valid) rdata_q <= bus.mem_rdata;
        RESPOND: ptr <= sel;
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = (state == IDLE && found) ? (NUM_REQ'(1) << win) : '0;
  assign bus.resp_valid    = (state == RESPOND) ? (NUM_REQ'(1) << sel) : '0;
  assign bus.resp_rdata    = rdata_q;
  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.busy          = (state != IDLE);
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one memory port among NUM_REQ requesters, such as per-core load/store units or the fetcher.
- One transaction is in flight at a time.
- Each accepted request is issued to memory, its response (read data or write ack) is awaited, and the result is returned to the requester that made it.
- It sits between the cores launched by the dispatcher and the global data memory.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters; legal range ≥1.
- ADDR_W, default 8: memory address width.
- DATA_W, default 32: data width; matches data_t.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- req_valid  in  [NUM_REQ-1:0]  requester i has a pending request.
- req_we  in  [NUM_REQ-1:0]  1 = write, 0 = read.
- req_addr  in  [NUM_REQ-1:0][ADDR_W-1:0]  per-requester address.
- req_wdata  in  [NUM_REQ-1:0][DATA_W-1:0]  per-requester write data.
- req_ready  out  [NUM_REQ-1:0]  one-hot, single-cycle accept pulse.
- resp_valid  out  [NUM_REQ-1:0]  one-hot, single-cycle response pulse to the owner.
- resp_rdata  out  DATA_W  read data, shared by all requesters; meaningful only while resp_valid is set.
- mem_req_valid  out  1  request to memory.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  memory response or write ack.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state is not IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - When any req_valid bit is set, select winner sel by round-robin.
  - Search order is ptr+1, ptr+2, … modulo NUM_REQ.
  - req_ready[sel] is combinational and asserted in this cycle.
  - Latch sel, req_we[sel], req_addr[sel] and req_wdata[sel]. Go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - Hold mem_req_valid=1 with the latched mem_we, mem_addr and mem_wdata, stable until mem_req_ready=1.
  - On mem_req_ready=1, go to WAIT. The next-cycle mem_req_valid is 0.
- WAIT:
  - On mem_resp_valid=1, latch mem_rdata into resp_rdata. Go to RESPOND.
  - Writes also wait for mem_resp_valid, which acts as the ack. For a write, the latched resp_rdata is don't-care.
- RESPOND:
  - resp_valid[sel]=1 for exactly one cycle.
  - Update ptr<=sel. Go to IDLE.
- Pointer rule: the reset value of ptr is NUM_REQ-1, so requester 0 has first priority. The last-granted requester has lowest priority in the next arbitration.
- Index width: sel and ptr are max(1,$clog2(NUM_REQ)) bits wide.
- Ignored inputs:
  - mem_resp_valid outside WAIT (memory must not respond before accept).
  - mem_req_ready outside ISSUE.
  - req_valid outside IDLE.
- Requester contract: after req_ready, the requester must deassert req_valid, or may present a new request. A new request cannot win until it is back in IDLE, so each requester has at most one outstanding transaction.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, state=IDLE, ptr=NUM_REQ-1.
- Latency for a request accepted in IDLE at cycle T:
  - mem_req_valid is registered and high at T+1.
  - With mem_req_ready=1 at T+1 and mem_resp_valid=1 at T+2, resp_valid is set at T+3.
  - The next grant is possible at T+4.
  - Minimum period is 4 cycles per transaction. Each stall cycle of mem_req_ready or mem_resp_valid adds one cycle.
- Simultaneous requests in IDLE: exactly one grant is issued. The others see no req_ready and keep req_valid asserted.
- busy is combinational from state: high from T+1 through T+3.
- Reset asserted mid-transaction:
  - All state and outputs return to reset values immediately.
  - The in-flight transaction is dropped and no resp_valid is issued.
  - A late memory response arriving after reset is ignored, because the FSM is in IDLE.
- NUM_REQ=1: the arbiter degenerates to a pass-through sequencer, and ptr stays 0.

## Test plan
- Single read: req_valid=4'b0001, addr 0x10; memory returns 0xDEADBEEF one cycle after accept → req_ready[0] at T, mem_addr=0x10 at T+1, resp_valid=4'b0001 with resp_rdata=0xDEADBEEF at T+3.
- Contention fairness: all four requesters held valid continuously → grants in order 0,1,2,3,0,1, one every 4 cycles, each resp_valid routed to the matching bit.
- Pointer skip: requests from 1 and 3 only, after a grant to 1 → next grant goes to 3, then to 1.
- Backpressure: mem_req_ready low for 3 cycles during a write of 0xA5A5A5A5 to 0x20 → mem_req_valid, mem_addr and mem_wdata stable throughout; resp_valid 3 cycles later than nominal.
- Spurious inputs: mem_resp_valid pulsed in IDLE and ISSUE → no state change and no resp_valid.
- Reset mid-WAIT: reset pulled low during WAIT → all outputs 0 at once; a later mem_resp_valid produces no resp_valid; the first grant after reset goes to requester 0.
